serial_fb_writer: RTL and testbench

- Converts the UART byte stream into 32-bit framebuffer words (two RGB565 pixels each) and issues single-word SDRAM write requests through the application port.
- Sits between the serial receiver and the SDRAM request mux, in the memory clock domain.
- Owns write address generation, frame wrap, byte-phase resynchronisation on idle gaps, and buffering while the controller is busy or video reads hold the port.

---
 rtl/serial_fb_writer_pkg.sv | 17 +
 rtl/serial_fb_writer_sync_fifo.sv | 65 ++++++
 rtl/serial_fb_writer.sv | 165 ++++++++++++++++
 tb/tb_serial_fb_writer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_fb_writer_pkg.sv
// Shared definitions for the serial framebuffer writer and its peers.
// The frame constants live here so that the video read-address generator
// walks exactly the same window that the writer fills.
package serial_fb_writer_pkg;

    // Write-request sequencing states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StData = 2'd2
    } wr_state_e;

    // Default framebuffer window: 640x480 RGB565, two pixels per word.
    localparam int unsigned FB_BASE_ADDR   = 0;
    localparam int unsigned FB_FRAME_WORDS = 153600;

endpackage

// File: rtl/serial_fb_writer_sync_fifo.sv
// Single-clock FIFO with show-ahead head output.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   push, wdata    write an entry (ignored when full)
//   pop            drop the head entry (ignored when empty)
//   rdata          current head entry, valid while !empty
//   full, empty    occupancy flags
module serial_fb_writer_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/serial_fb_writer.sv
// Packs the UART byte stream into 32-bit framebuffer words (two big-endian
// RGB565 pixels, first pixel in [31:16]) and issues single-word SDRAM writes.
// Ports:
//   mem_clk, reset            memory-domain clock, synchronous active-high reset
//   sr_data_rdy, sr_data      received byte strobe and value
//   wr_hold                   blocks starting a new request (video read priority)
//   mem_wr_req/addr/data      write request to the controller
//   mem_ack, mem_wr_data_next controller accepted request / consumed data word
//   frame_sync                one-cycle pulse on idle-gap resync
//   overflow                  sticky: a completed word was dropped (FIFO full)
//   words_written             words completed since reset, wraps
module serial_fb_writer
    import serial_fb_writer_pkg::*;
#(
    parameter int unsigned AW          = 25,
    parameter int unsigned BASE_ADDR   = FB_BASE_ADDR,
    parameter int unsigned FRAME_WORDS = FB_FRAME_WORDS,
    parameter int unsigned TIMEOUT     = 80000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic          mem_clk,
    input  logic          reset,
    input  logic          sr_data_rdy,
    input  logic [7:0]    sr_data,
    input  logic          wr_hold,
    output logic          mem_wr_req,
    output logic [AW-1:0] mem_wr_addr,
    output logic [31:0]   mem_wr_data,
    input  logic          mem_ack,
    input  logic          mem_wr_data_next,
    output logic          frame_sync,
    output logic          overflow,
    output logic [AW-1:0] words_written
);

    localparam int unsigned   TW         = $clog2(TIMEOUT + 1);
    localparam int unsigned   EW         = AW + 32;
    localparam logic [AW-1:0] FIRST_ADDR = AW'(BASE_ADDR);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(BASE_ADDR + FRAME_WORDS - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    logic [1:0]    phase_q;
    logic [23:0]   partial_q;
    logic          push_q;
    logic [31:0]   push_data_q;
    logic [AW-1:0] wr_addr_q;
    logic [TW-1:0] to_cnt_q;
    logic          to_armed_q;
    logic          timeout_hit;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [EW-1:0] fifo_head;
    wr_state_e     state_q;

    // A byte in the terminal cycle keeps the stream alive.
    assign timeout_hit = to_armed_q && !sr_data_rdy && (to_cnt_q == TO_LAST);

    // The head entry leaves the FIFO only once the controller took the data.
    assign fifo_pop = ((state_q == StReq) && mem_ack && mem_wr_data_next) ||
                      ((state_q == StData) && mem_wr_data_next);

    // Byte packing, idle-gap resync and write-address generation.
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            phase_q     <= 2'd0;
            partial_q   <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            wr_addr_q   <= FIRST_ADDR;
            to_cnt_q    <= '0;
            to_armed_q  <= 1'b0;
            frame_sync  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            frame_sync <= 1'b0;
            if (sr_data_rdy) begin
                to_cnt_q   <= '0;
                to_armed_q <= 1'b1;
                phase_q    <= phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    push_q      <= 1'b1;
                    push_data_q <= {partial_q, sr_data};
                end else begin
                    partial_q <= {partial_q[15:0], sr_data};
                end
            end else if (timeout_hit) begin
                // Partial word is abandoned by restarting the phase.
                phase_q    <= 2'd0;
                to_cnt_q   <= '0;
                to_armed_q <= 1'b0;
                frame_sync <= 1'b1;
            end else if (to_armed_q) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            // Dropped words still consume an address to keep screen position.
            if (timeout_hit) begin
                wr_addr_q <= FIRST_ADDR;
            end else if (push_q) begin
                wr_addr_q <= (wr_addr_q == LAST_ADDR) ? FIRST_ADDR : wr_addr_q + 1'b1;
            end

            if (push_q && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    serial_fb_writer_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (mem_clk),
        .reset (reset),
        .push  (push_q),
        .wdata ({wr_addr_q, push_data_q}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Request sequencing; wr_hold only gates the start of a request.
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            state_q       <= StIdle;
            mem_wr_req    <= 1'b0;
            mem_wr_addr   <= FIRST_ADDR;
            mem_wr_data   <= '0;
            words_written <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty && !wr_hold) begin
                        mem_wr_req  <= 1'b1;
                        mem_wr_addr <= fifo_head[EW-1:32];
                        mem_wr_data <= fifo_head[31:0];
                        state_q     <= StReq;
                    end
                end
                StReq: begin
                    if (mem_ack) begin
                        mem_wr_req <= 1'b0;
                        if (mem_wr_data_next) begin
                            words_written <= words_written + 1'b1;
                            state_q       <= StIdle;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (mem_wr_data_next) begin
                        words_written <= words_written + 1'b1;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_fb_writer.sv
// Bench for serial_fb_writer: directed byte streams, a responding controller
// model, and a queue-based reference of the words that must be written.
module tb_serial_fb_writer;

    localparam int unsigned AW    = 16;
    localparam int unsigned BASE  = 16;
    localparam int unsigned FW    = 8;
    localparam int unsigned TO    = 64;
    localparam int unsigned DEPTH = 4;

    logic          mem_clk = 1'b0;
    logic          reset = 1'b1;
    logic          sr_data_rdy = 1'b0;
    logic [7:0]    sr_data = 8'h00;
    logic          wr_hold = 1'b0;
    logic          mem_wr_req;
    logic [AW-1:0] mem_wr_addr;
    logic [31:0]   mem_wr_data;
    logic          mem_ack = 1'b0;
    logic          mem_wr_data_next = 1'b0;
    logic          frame_sync;
    logic          overflow;
    logic [AW-1:0] words_written;

    always #5 mem_clk = ~mem_clk;

    serial_fb_writer #(
        .AW          (AW),
        .BASE_ADDR   (BASE),
        .FRAME_WORDS (FW),
        .TIMEOUT     (TO),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .mem_clk          (mem_clk),
        .reset            (reset),
        .sr_data_rdy      (sr_data_rdy),
        .sr_data          (sr_data),
        .wr_hold          (wr_hold),
        .mem_wr_req       (mem_wr_req),
        .mem_wr_addr      (mem_wr_addr),
        .mem_wr_data      (mem_wr_data),
        .mem_ack          (mem_ack),
        .mem_wr_data_next (mem_wr_data_next),
        .frame_sync       (frame_sync),
        .overflow         (overflow),
        .words_written    (words_written)
    );

    int nvec = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: words still owed to memory, in order, plus sticky/ counted state.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] m_bytes[$];
    int         m_addr = BASE;
    bit         m_pend = 0;
    wr_t        m_pend_w;
    bit         m_ovf = 0;
    int         m_ww = 0;
    bit         m_fs = 0;
    int         m_idle = 0;
    bit         m_armed = 0;

    always @(posedge mem_clk) begin
        if (reset) begin
            exp_q.delete();
            m_bytes.delete();
            m_addr  = BASE;
            m_pend  = 0;
            m_ovf   = 0;
            m_ww    = 0;
            m_fs    = 0;
            m_idle  = 0;
            m_armed = 0;
        end else begin
            m_fs = 0;
            // A completed word lands in the queue one cycle after its last byte.
            if (m_pend) begin
                if (exp_q.size() >= DEPTH) m_ovf = 1;
                else exp_q.push_back(m_pend_w);
                m_pend = 0;
            end
            if (mem_wr_data_next) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_ww = (m_ww + 1) % (1 << AW);
            end
            if (sr_data_rdy) begin
                m_bytes.push_back(sr_data);
                m_idle  = 0;
                m_armed = 1;
                if (m_bytes.size() == 4) begin
                    m_pend_w.addr = AW'(m_addr);
                    m_pend_w.data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                    m_pend = 1;
                    m_bytes.delete();
                    m_addr = (m_addr == BASE + FW - 1) ? BASE : m_addr + 1;
                end
            end else if (m_armed) begin
                // TO byte-less cycles after the last byte mean resync.
                m_idle++;
                if (m_idle == TO) begin
                    m_bytes.delete();
                    m_addr  = BASE;
                    m_fs    = 1;
                    m_armed = 0;
                end
            end
        end
    end

    // Compare against the reference, then act as the SDRAM controller.
    int         ack_dly = 1;
    int         dn_dly = 1;
    int         rs = 0;
    int         rcnt = 0;
    logic       prev_req = 1'b0;
    logic       prev_ack;
    int         fs_count = 0;
    logic [AW-1:0] seen_addr[$];
    logic [31:0]   seen_data[$];

    always @(posedge mem_clk) begin
        #1;
        prev_ack = mem_ack;
        chk("words_written", 64'(words_written), 64'(m_ww));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("frame_sync", 64'(frame_sync), 64'(m_fs));
        if (frame_sync) fs_count++;
        if (mem_wr_req) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL req_unexpected: got addr %h data %h, want no request",
                         mem_wr_addr, mem_wr_data);
            end else begin
                chk("req_addr_data", 64'({mem_wr_addr, mem_wr_data}),
                    64'({exp_q[0].addr, exp_q[0].data}));
            end
            if (!prev_req) begin
                seen_addr.push_back(mem_wr_addr);
                seen_data.push_back(mem_wr_data);
            end
        end
        if (prev_ack) chk("req_drop_after_ack", 64'(mem_wr_req), 64'(0));
        prev_req = mem_wr_req;

        mem_ack = 1'b0;
        mem_wr_data_next = 1'b0;
        if (reset) begin
            rs = 0;
        end else begin
            if (rs == 0 && mem_wr_req) begin
                rs = 1;
                rcnt = 0;
            end else if (rs == 1) begin
                rcnt++;
            end else if (rs == 2) begin
                rcnt++;
                if (rcnt == dn_dly) begin
                    mem_wr_data_next = 1'b1;
                    rs = 0;
                end
            end
            if (rs == 1 && rcnt == ack_dly) begin
                mem_ack = 1'b1;
                rcnt = 0;
                if (dn_dly == 0) begin
                    mem_wr_data_next = 1'b1;
                    rs = 0;
                end else begin
                    rs = 2;
                end
            end
        end
    end

    // Called at a negedge; holds the strobe for exactly one cycle.
    task automatic strobe(input logic [7:0] v);
        sr_data_rdy = 1'b1;
        sr_data = v;
        @(negedge mem_clk);
        sr_data_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge mem_clk);
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (i < budget && (exp_q.size() != 0 || m_pend)) begin
            @(negedge mem_clk);
            i++;
        end
        if (exp_q.size() != 0 || m_pend) begin
            nvec++;
            nfail++;
            $display("FAIL drain_timeout: %0d words pending, want 0", exp_q.size());
        end
    endtask

    task automatic wait_req(input int budget);
        int i;
        i = 0;
        while (i < budget && !mem_wr_req) begin
            @(negedge mem_clk);
            i++;
        end
        if (!mem_wr_req) begin
            nvec++;
            nfail++;
            $display("FAIL req_timeout: got mem_wr_req 0, want 1");
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge mem_clk);
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req"}, 64'(mem_wr_req), 64'(0));
        chk({tag, "_addr"}, 64'(mem_wr_addr), 64'(16));
        chk({tag, "_data"}, 64'(mem_wr_data), 64'(0));
        chk({tag, "_ovf"}, 64'(overflow), 64'(0));
        chk({tag, "_ww"}, 64'(words_written), 64'(0));
        chk({tag, "_fs"}, 64'(frame_sync), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_ww;
        repeat (3) @(negedge mem_clk);
        reset = 1'b0;
        chk_reset_state("reset");

        // 1: spaced bytes, single write with delayed ack/data handshake.
        ack_dly = 2;
        dn_dly = 3;
        strobe(8'h12); idle(10);
        strobe(8'h34); idle(10);
        strobe(8'h56); idle(10);
        strobe(8'h78);
        chk("lat_t1_req", 64'(mem_wr_req), 64'(0));
        idle(1);
        chk("lat_t2_req", 64'(mem_wr_req), 64'(0));
        idle(1);
        chk("lat_t3_req", 64'(mem_wr_req), 64'(1));
        chk("t1_addr", 64'(mem_wr_addr), 64'(16));
        chk("t1_data", 64'(mem_wr_data), 64'h12345678);
        idle(2);
        chk("t1_req_in_ack_cycle", 64'(mem_wr_req), 64'(1));
        idle(1);
        chk("t1_req_after_ack", 64'(mem_wr_req), 64'(0));
        wait_drain(50);
        chk("t1_ww", 64'(words_written), 64'(1));
        idle(TO + 5);

        // 2: continuous stream, address wraps twice.
        ack_dly = 0;
        dn_dly = 0;
        seen_addr.delete();
        seen_data.delete();
        for (int i = 0; i < 80; i++) strobe(8'(i * 3 + 1));
        wait_drain(100);
        chk("t2_count", 64'(seen_addr.size()), 64'(20));
        if (seen_addr.size() == 20) begin
            chk("t2_addr7", 64'(seen_addr[7]), 64'(23));
            chk("t2_addr8", 64'(seen_addr[8]), 64'(16));
            chk("t2_addr19", 64'(seen_addr[19]), 64'(19));
            chk("t2_data0", 64'(seen_data[0]), 64'h0104070a);
        end
        idle(TO + 5);

        // 3: hold while six words arrive; two are dropped.
        ack_dly = 1;
        dn_dly = 1;
        seen_addr.delete();
        wr_hold = 1'b1;
        for (int i = 0; i < 24; i++) strobe(8'(8'h80 + i));
        idle(4);
        chk("t3_req_held", 64'(mem_wr_req), 64'(0));
        chk("t3_ovf", 64'(overflow), 64'(1));
        base_ww = m_ww;
        wr_hold = 1'b0;
        for (int i = 0; i < 40 && m_ww == base_ww; i++) @(negedge mem_clk);
        for (int i = 0; i < 4; i++) strobe(8'(8'hc0 + i));
        wait_drain(100);
        chk("t3_count", 64'(seen_addr.size()), 64'(5));
        if (seen_addr.size() == 5) begin
            chk("t3_addr0", 64'(seen_addr[0]), 64'(16));
            chk("t3_addr3", 64'(seen_addr[3]), 64'(19));
            chk("t3_addr4", 64'(seen_addr[4]), 64'(22));
        end
        chk("t3_ww", 64'(words_written), 64'(26));
        idle(TO + 5);

        // 4: partial word then long gap: one pulse, next word restarts at base.
        fs_count = 0;
        seen_addr.delete();
        seen_data.delete();
        strobe(8'ha1); strobe(8'ha2); strobe(8'ha3);
        idle(3 * TO);
        chk("t4_fs_pulses", 64'(fs_count), 64'(1));
        strobe(8'hb1); strobe(8'hb2); strobe(8'hb3); strobe(8'hb4);
        wait_drain(50);
        chk("t4_count", 64'(seen_addr.size()), 64'(1));
        if (seen_addr.size() == 1) begin
            chk("t4_addr", 64'(seen_addr[0]), 64'(16));
            chk("t4_data", 64'(seen_data[0]), 64'hb1b2b3b4);
        end
        idle(2 * TO);

        // 5: each byte lands exactly in the terminal timeout cycle.
        fs_count = 0;
        seen_addr.delete();
        seen_data.delete();
        strobe(8'hc1); idle(TO - 1);
        strobe(8'hc2); idle(TO - 1);
        strobe(8'hc3); idle(TO - 1);
        strobe(8'hc4);
        chk("t5_fs_pulses", 64'(fs_count), 64'(0));
        wait_drain(50);
        chk("t5_count", 64'(seen_addr.size()), 64'(1));
        if (seen_addr.size() == 1) begin
            chk("t5_addr", 64'(seen_addr[0]), 64'(16));
            chk("t5_data", 64'(seen_data[0]), 64'hc1c2c3c4);
        end
        chk("t5_ww", 64'(words_written), 64'(28));
        idle(TO + 5);

        // 6: reset in REQ, then in DATA, then a clean write.
        ack_dly = 6;
        dn_dly = 1;
        strobe(8'hd1); strobe(8'hd2); strobe(8'hd3); strobe(8'hd4);
        wait_req(20);
        idle(2);
        pulse_reset();
        chk_reset_state("rst_req");
        ack_dly = 0;
        dn_dly = 4;
        strobe(8'he1); strobe(8'he2); strobe(8'he3); strobe(8'he4);
        wait_req(20);
        idle(1);
        chk("t6_in_data_req", 64'(mem_wr_req), 64'(0));
        pulse_reset();
        chk_reset_state("rst_data");
        idle(5);
        chk("t6_fifo_empty", 64'(mem_wr_req), 64'(0));
        ack_dly = 1;
        dn_dly = 1;
        seen_addr.delete();
        seen_data.delete();
        strobe(8'hf1); strobe(8'hf2); strobe(8'hf3); strobe(8'hf4);
        wait_drain(50);
        chk("t6_count", 64'(seen_addr.size()), 64'(1));
        if (seen_addr.size() == 1) begin
            chk("t6_addr", 64'(seen_addr[0]), 64'(16));
            chk("t6_data", 64'(seen_data[0]), 64'hf1f2f3f4);
        end
        chk("t6_ww", 64'(words_written), 64'(1));
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
